// File: rtl/clkdiv_prog_mc_if.sv
// Control/status bundle for the multi-channel programmable divider.
// The divider-side modport is slave; the controlling block is master.
interface clkdiv_prog_mc_if #(
  parameter int N = 2,
  parameter int W = 4
);
  logic [N-1:0]   en;
  logic [N*W-1:0] div;
  logic           sync;
  logic [N-1:0]   out;
  logic [N-1:0]   tick;
  logic [N-1:0]   reload;

  modport master (output en, div, sync, input  out, tick, reload);
  modport slave  (input  en, div, sync, output out, tick, reload);
endinterface

// File: rtl/clkdiv_prog_mc.sv
// N-channel programmable divider with glitch-free ratio reload and a common
// phase-aligning sync. One lane instance per channel; all lane outputs are registered.
module clkdiv_prog_lane #(
  parameter int W = 4
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sync,
  input  logic [W-1:0] div,
  output logic         out,
  output logic         tick,
  output logic         reload
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] diva;
  logic [W-1:0] cnt_inc;
  logic         start;

  assign start   = en && (div != '0);
  assign cnt_inc = cnt + 1'b1;

  // out is derived from the post-edge cnt/diva, so it is computed alongside them.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      diva   <= '0;
      out    <= 1'b0;
      tick   <= 1'b0;
      reload <= 1'b0;
    end else if (sync && start) begin
      state  <= RUN;
      cnt    <= '0;
      diva   <= div;
      out    <= 1'b1;
      tick   <= 1'b1;
      reload <= (div != diva);
    end else begin
      case (state)
        IDLE: begin
          cnt    <= '0;
          diva   <= div;
          reload <= 1'b0;
          out    <= start;
          tick   <= start;
          if (start) state <= RUN;
        end
        RUN: begin
          if (cnt < diva) begin
            cnt    <= cnt_inc;
            out    <= (cnt_inc <= (diva >> 1));
            tick   <= 1'b0;
            reload <= 1'b0;
          end else if (start) begin
            cnt    <= '0;
            diva   <= div;
            out    <= 1'b1;
            tick   <= 1'b1;
            reload <= (div != diva);
          end else begin
            // Ratio is kept so a later sync can still flag a change.
            state  <= IDLE;
            cnt    <= '0;
            out    <= 1'b0;
            tick   <= 1'b0;
            reload <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

module clkdiv_prog_mc #(
  parameter int N = 2,
  parameter int W = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  clkdiv_prog_mc_if.slave  bus
);
  for (genvar k = 0; k < N; k++) begin : g_lane
    clkdiv_prog_lane #(.W(W)) u_lane (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .en     (bus.en[k]),
      .sync   (bus.sync),
      .div    (bus.div[k*W +: W]),
      .out    (bus.out[k]),
      .tick   (bus.tick[k]),
      .reload (bus.reload[k])
    );
  end
endmodule

// File: tb/tb_clkdiv_prog_mc.sv
// Bench for clkdiv_prog_mc: directed scenarios plus random traffic, each cycle
// compared against a period/phase reference model.
module tb_clkdiv_prog_mc;
  localparam int N = 2;
  localparam int W = 4;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  clkdiv_prog_mc_if #(.N(N), .W(W)) bus ();

  clkdiv_prog_mc #(.N(N), .W(W)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: whether a channel runs, its period length P and the
  // cycle index inside the current period.
  bit m_run [N];
  int m_p   [N];
  int m_ph  [N];
  bit m_tick[N];
  bit m_rel [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_run[k] = 0; m_p[k] = 1; m_ph[k] = 0; m_tick[k] = 0; m_rel[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      int  d;
      bit  ok;
      d  = int'(bus.div[k*W +: W]);
      ok = bus.en[k] && (d != 0);
      m_tick[k] = 0;
      m_rel[k]  = 0;
      if (bus.sync && ok) begin
        m_rel[k] = ((d + 1) != m_p[k]);
        m_run[k] = 1; m_p[k] = d + 1; m_ph[k] = 0; m_tick[k] = 1;
      end else if (!m_run[k]) begin
        m_p[k] = d + 1; m_ph[k] = 0;
        if (ok) begin m_run[k] = 1; m_tick[k] = 1; end
      end else if (m_ph[k] < m_p[k] - 1) begin
        m_ph[k]++;
      end else if (ok) begin
        m_rel[k] = ((d + 1) != m_p[k]);
        m_p[k] = d + 1; m_ph[k] = 0; m_tick[k] = 1;
      end else begin
        m_run[k] = 0; m_ph[k] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] e_out, e_tick, e_rel;
    for (int k = 0; k < N; k++) begin
      e_out[k]  = m_run[k] && (m_ph[k] < (m_p[k] + 1) / 2);
      e_tick[k] = m_tick[k];
      e_rel[k]  = m_rel[k];
    end
    chk({tag, "_out"},    32'(bus.out),    32'(e_out));
    chk({tag, "_tick"},   32'(bus.tick),   32'(e_tick));
    chk({tag, "_reload"}, 32'(bus.reload), 32'(e_rel));
  endtask

  task automatic step(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      if (!rst_n) model_reset(); else model_edge();
      #1;
      check_all(tag);
    end
  endtask

  task automatic set_div(input int k, input int v);
    bus.div[k*W +: W] = W'(v);
  endtask

  task automatic pulse_sync(input string tag);
    bus.sync = 1'b1;
    step(1, tag);
    bus.sync = 1'b0;
  endtask

  // Advance channel 0 until it sits at the requested phase (bounded).
  task automatic wait_ph0(input int ph, input string tag);
    int i;
    i = 0;
    while (!(m_run[0] && m_ph[0] == ph) && i < 40) begin
      step(1, tag);
      i++;
    end
    chk({tag, "_reach_phase"}, 32'(m_ph[0] == ph && m_run[0]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel_cnt;
    model_reset();
    bus.en = '0; bus.div = '0; bus.sync = 1'b0;
    #1;
    chk("reset_out",    32'(bus.out),    32'd0);
    chk("reset_tick",   32'(bus.tick),   32'd0);
    chk("reset_reload", 32'(bus.reload), 32'd0);
    @(negedge clk_in); rst_n = 1'b1;
    step(2, "idle");

    // Reset asserted between edges while channel 0 runs.
    set_div(0, 3); bus.en[0] = 1'b1;
    step(1, "rst_pre");
    step(1, "rst_pre");
    #2; rst_n = 1'b0; #1;
    chk("rst_async_out",    32'(bus.out),    32'd0);
    chk("rst_async_tick",   32'(bus.tick),   32'd0);
    chk("rst_async_reload", 32'(bus.reload), 32'd0);
    bus.en = '0;
    model_reset();
    @(negedge clk_in); rst_n = 1'b1;
    step(4, "rst_post");
    chk("rst_post_out", 32'(bus.out), 32'd0);

    // div=1 then div=2.
    set_div(0, 1); bus.en[0] = 1'b1;
    step(1, "div1");
    chk("div1_first_out",  32'(bus.out[0]),  32'd1);
    chk("div1_first_tick", 32'(bus.tick[0]), 32'd1);
    step(1, "div1");
    chk("div1_second_out", 32'(bus.out[0]),  32'd0);
    step(5, "div1");
    set_div(0, 2);
    step(10, "div2");

    // Ratio change 3->5 at phase 1; reload must pulse exactly once.
    set_div(0, 3);
    wait_ph0(1, "chg");
    set_div(0, 5);
    rel_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, "chg");
      if (bus.reload[0]) rel_cnt++;
    end
    chk("chg_reload_once", 32'(rel_cnt), 32'd1);

    // Sync alignment of div 3 and div 5 started at different times.
    bus.en = '0;
    step(8, "sync_drain");
    set_div(1, 5); bus.en[1] = 1'b1;
    step(2, "sync_pre");
    set_div(0, 3); bus.en[0] = 1'b1;
    step(3, "sync_pre");
    pulse_sync("sync");
    chk("sync_aligned_tick", 32'(bus.tick), 32'h3);
    chk("sync_reload",       32'(bus.reload), 32'h0);
    step(12, "sync_post");
    chk("sync_12_tick", 32'(bus.tick), 32'h3);
    step(12, "sync_post");
    chk("sync_24_tick", 32'(bus.tick), 32'h3);

    // Graceful disable at phase 1, then re-enable.
    bus.en[1] = 1'b0;
    wait_ph0(1, "dis");
    bus.en[0] = 1'b0;
    step(8, "dis");
    chk("dis_hold_out", 32'(bus.out[0]), 32'd0);
    bus.en[0] = 1'b1;
    step(1, "reen");
    chk("reen_out",  32'(bus.out[0]),  32'd1);
    chk("reen_tick", 32'(bus.tick[0]), 32'd1);

    // Stop ratio then maximum ratio.
    set_div(0, 0);
    step(6, "stop");
    pulse_sync("stop_sync");
    chk("stop_sync_out", 32'(bus.out[0]), 32'd0);
    step(3, "stop");
    set_div(0, 15);
    step(40, "max");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) bus.en = N'($urandom);
      if ($urandom_range(0, 5) == 0) set_div($urandom_range(0, N - 1), $urandom_range(0, 6));
      if ($urandom_range(0, 40) == 0) set_div($urandom_range(0, N - 1), 15);
      bus.sync = ($urandom_range(0, 15) == 0);
      step(1, "rand");
    end
    bus.sync = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
